bcd_serial_subtractor: RTL and testbench

//   Digit-serial BCD subtractor, the inverse operation of the BCD adder: computes |A-B| for two

---
 rtl/bcd_serial_subtractor_pkg.sv | 20 ++
 rtl/bcd_serial_subtractor_if.sv | 28 ++
 rtl/bcd_serial_subtractor_digit_sub.sv | 24 ++
 rtl/bcd_serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared constants, FSM encoding and digit helpers for the serial BCD subtractor.
package bcd_serial_subtractor_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned BCD_MAX     = 9;
    localparam int unsigned BCD_BASE    = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_NEGATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // True when a nibble is not a legal BCD digit.
    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Request/result bundle between a requester and the serial BCD subtractor.
interface bcd_serial_subtractor_if #(
    parameter int unsigned DIGITS = 2
);
    import bcd_serial_subtractor_pkg::*;

    localparam int unsigned W = BCD_DIGIT_W * DIGITS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         neg;
    logic         flag;

    modport master (
        output start, a, b,
        input  busy, done, diff, neg, flag
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, neg, flag
    );

endinterface

// File: rtl/bcd_serial_subtractor_digit_sub.sv
// One BCD digit of a - b - borrow_in, producing a corrected digit and borrow_out.
module bcd_serial_subtractor_digit_sub
    import bcd_serial_subtractor_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_i,
    input  logic [BCD_DIGIT_W-1:0] b_i,
    input  logic                   bin_i,
    output logic [BCD_DIGIT_W-1:0] d_c_o,
    output logic                   bout_c_o
);

    logic [BCD_DIGIT_W:0] t_c;

    // 5-bit two's complement difference; a negative result is folded back by adding ten.
    always_comb begin
        t_c      = {1'b0, a_i} - {1'b0, b_i} - (BCD_DIGIT_W+1)'(bin_i);
        bout_c_o = t_c[BCD_DIGIT_W];
        d_c_o    = t_c[BCD_DIGIT_W-1:0];
        if (t_c[BCD_DIGIT_W]) begin
            d_c_o = BCD_DIGIT_W'(t_c + (BCD_DIGIT_W+1)'(BCD_BASE));
        end
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial |a-b| on packed BCD, LSD first, with a ten's-complement fix-up pass.
module bcd_serial_subtractor
    import bcd_serial_subtractor_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bcd_serial_subtractor_if.slave   bus
);

    localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   borrow_q;
    logic [W-1:0]           op_a_q;
    logic [W-1:0]           op_b_q;
    logic [W-1:0]           work_q;
    logic [W-1:0]           diff_q;
    logic                   neg_q;
    logic                   flag_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   bad_c;
    logic [BCD_DIGIT_W-1:0] sub_a_c;
    logic [BCD_DIGIT_W-1:0] sub_b_c;
    logic [BCD_DIGIT_W-1:0] sub_d_c;
    logic                   sub_bout_c;
    logic [W-1:0]           work_nx_c;

    // Any non-BCD nibble on the live request operands.
    always_comb begin
        bad_c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(bus.a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                digit_invalid(bus.b[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                bad_c = 1'b1;
            end
        end
    end

    // Operand mux: RUN subtracts the captured operands, NEGATE computes 0 - work.
    always_comb begin
        sub_a_c = op_a_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];
        sub_b_c = op_b_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];
        if (state_q == S_NEGATE) begin
            sub_a_c = '0;
            sub_b_c = work_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];
        end
    end

    bcd_serial_subtractor_digit_sub u_digit_sub (
        .a_i      (sub_a_c),
        .b_i      (sub_b_c),
        .bin_i    (borrow_q),
        .d_c_o    (sub_d_c),
        .bout_c_o (sub_bout_c)
    );

    // Work register with the current digit replaced, so the final digit reaches diff directly.
    always_comb begin
        work_nx_c = work_q;
        work_nx_c[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W] = sub_d_c;
    end

    // Control FSM, digit counter, operand/work/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            work_q   <= '0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_a_q   <= bus.a;
                        op_b_q   <= bus.b;
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        work_q   <= '0;
                        if (bad_c) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            diff_q  <= '0;
                            neg_q   <= 1'b0;
                            flag_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    work_q <= work_nx_c;
                    if (idx_q == LAST_IDX) begin
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        if (sub_bout_c) begin
                            state_q <= S_NEGATE;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            diff_q  <= work_nx_c;
                            neg_q   <= 1'b0;
                            flag_q  <= 1'b0;
                        end
                    end else begin
                        idx_q    <= idx_q + IDX_W'(1);
                        borrow_q <= sub_bout_c;
                    end
                end
                S_NEGATE: begin
                    work_q <= work_nx_c;
                    if (idx_q == LAST_IDX) begin
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        diff_q   <= work_nx_c;
                        neg_q    <= 1'b1;
                        flag_q   <= 1'b0;
                    end else begin
                        idx_q    <= idx_q + IDX_W'(1);
                        borrow_q <= sub_bout_c;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.neg  = neg_q;
    assign bus.flag = flag_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed and exhaustive checks of the serial BCD subtractor at DIGITS=2.
module tb_bcd_serial_subtractor;

    localparam int unsigned DIGITS = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is off.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Issue one operation from a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_diff, input logic exp_neg,
                          input logic exp_flag, input int exp_busy);
        int lat;
        int bcnt;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        lat  = 0;
        bcnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
            if (bus.busy) bcnt++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_busy + 1));
        chk({name, " busy"},    32'(bcnt), 32'(exp_busy));
        chk({name, " diff"},    32'(bus.diff), 32'(exp_diff));
        chk({name, " neg"},     32'(bus.neg), 32'(exp_neg));
        chk({name, " flag"},    32'(bus.flag), 32'(exp_flag));
        @(negedge clk);
        chk({name, " done_drop"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dcnt;
        int va;
        int vb;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset diff", 32'(bus.diff), 32'd0);
        chk("reset neg",  32'(bus.neg),  32'd0);
        chk("reset flag", 32'(bus.flag), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("42-17", 8'h42, 8'h17, 8'h25, 1'b0, 1'b0, 2);
        run_op("17-42", 8'h17, 8'h42, 8'h25, 1'b1, 1'b0, 4);
        run_op("00-01", 8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 4);
        run_op("50-50", 8'h50, 8'h50, 8'h00, 1'b0, 1'b0, 2);
        run_op("99-00", 8'h99, 8'h00, 8'h99, 1'b0, 1'b0, 2);
        run_op("00-99", 8'h00, 8'h99, 8'h99, 1'b1, 1'b0, 4);
        run_op("3A-11", 8'h3A, 8'h11, 8'h00, 1'b0, 1'b1, 0);
        run_op("05-A0", 8'h05, 8'hA0, 8'h00, 1'b0, 1'b1, 0);
        run_op("10-05", 8'h10, 8'h05, 8'h05, 1'b0, 1'b0, 2);

        // Start re-pulsed while the operation is running must be ignored.
        bus.a     = 8'h42;
        bus.b     = 8'h17;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
            bus.start = (i == 0);
        end
        chk("start_in_run dones", 32'(dcnt), 32'd1);
        chk("start_in_run diff",  32'(bus.diff), 32'h25);

        // Start held high: a new op every four cycles (run, run, done, idle-accept).
        bus.a     = 8'h50;
        bus.b     = 8'h20;
        bus.start = 1'b1;
        @(posedge clk);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        bus.start = 1'b0;
        chk("held_start dones", 32'(dcnt), 32'd3);
        chk("held_start diff",  32'(bus.diff), 32'h30);
        repeat (8) @(negedge clk);

        // Reset during RUN clears everything at once.
        bus.a     = 8'h17;
        bus.b     = 8'h42;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        chk("midrst diff", 32'(bus.diff), 32'd0);
        chk("midrst neg",  32'(bus.neg),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst 10-05", 8'h10, 8'h05, 8'h05, 1'b0, 1'b0, 2);

        // Exhaustive sweep against integer arithmetic.
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 100; j++) begin
                va = i;
                vb = j;
                run_op($sformatf("sweep %0d-%0d", va, vb), to_bcd(va), to_bcd(vb),
                       to_bcd((va >= vb) ? va - vb : vb - va), (va < vb), 1'b0,
                       (va < vb) ? 2 * DIGITS : DIGITS);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
